// File: rtl/imem_lat.sv
// imem_lat: multi-cycle instruction memory with fixed read latency, flush abort
// and an independent synchronous program-load write port.
module imem_lat #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH = 1024,
   parameter int LATENCY = 4,
   parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              flush,
   output logic [DATA_W-1:0] instr,
   output logic              instr_vld,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(LATENCY) + 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] addr_q, rd_idx, wr_idx;
   logic [CW-1:0] cnt;
   assign rd_idx = AW'(addr);
   assign wr_idx = AW'(wr_addr);
   assign busy = state == BUSY;
   always_ff @(posedge clk)
      if (rst_n && wr_en) mem[wr_idx] <= wr_data;
   // the completion read samples mem before any same-edge write lands
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         instr <= NOP_INSTR;
         instr_vld <= 1'b0;
      end else begin
         instr_vld <= 1'b0;
         if (state == BUSY && !flush) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               instr <= mem[addr_q];
               instr_vld <= 1'b1;
               state <= IDLE;
            end
         end else if (rd_en) begin
            addr_q <= rd_idx;
            if (LATENCY == 1) begin
               instr <= mem[rd_idx];
               instr_vld <= 1'b1;
            end else begin
               cnt <= CW'(LATENCY - 1);
               state <= BUSY;
            end
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_imem_lat.sv
// tb_imem_lat: drives a LATENCY=4 and a LATENCY=1 instance with the same stimulus
// and checks both every cycle against an event-time model plus literal expectations.
module tb_imem_lat;
   logic clk = 1'b0;
   logic rst_n = 1'b0, rd_en = 1'b0, flush = 1'b0, wr_en = 1'b0;
   logic [15:0] addr = '0, wr_addr = '0, wr_data = '0;
   logic [15:0] instr4, instr1;
   logic vld4, vld1, busy4, busy1;
   int tests = 0, fails = 0;
   bit chk = 1'b0;

   imem_lat #(.LATENCY(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr(addr), .flush(flush),
      .instr(instr4), .instr_vld(vld4), .busy(busy4),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
   imem_lat #(.LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr(addr), .flush(flush),
      .instr(instr1), .instr_vld(vld1), .busy(busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   always #5 clk = ~clk;

   // model: a fetch accepted on edge e completes on edge e+L-1; flush or reset drops it
   logic [15:0] mm [1024];
   int lat [2] = '{4, 1};
   bit pend [2], acc_ok [2], ev [2];
   logic [15:0] ei [2];
   logic [9:0] pa [2];
   int done [2];
   int edge_n = 0;
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            pend[k] = 1'b0;
            ev[k] = 1'b0;
            ei[k] = 16'h0000;
         end else begin
            acc_ok[k] = !pend[k] || flush;
            ev[k] = 1'b0;
            if (pend[k] && !flush && edge_n == done[k]) begin
               ei[k] = mm[pa[k]];
               ev[k] = 1'b1;
            end
            if (pend[k] && (flush || edge_n == done[k])) pend[k] = 1'b0;
            if (acc_ok[k] && rd_en) begin
               if (lat[k] == 1) begin
                  ei[k] = mm[addr[9:0]];
                  ev[k] = 1'b1;
               end else begin
                  pend[k] = 1'b1;
                  pa[k] = addr[9:0];
                  done[k] = edge_n + lat[k] - 1;
               end
            end
         end
      end
      if (rst_n && wr_en) mm[wr_addr[9:0]] = wr_data;
      edge_n++;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) if (chk) begin
      check("m_instr4", instr4, ei[0]);
      check("m_vld4", 16'(vld4), 16'(ev[0]));
      check("m_busy4", 16'(busy4), 16'(pend[0]));
      check("m_instr1", instr1, ei[1]);
      check("m_vld1", 16'(vld1), 16'(ev[1]));
      check("m_busy1", 16'(busy1), 16'(pend[1]));
   end

   task automatic cyc(); @(negedge clk); endtask
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask
   task automatic req(input logic [15:0] a);
      rd_en = 1'b1; addr = a;
      cyc();
      rd_en = 1'b0;
   endtask

   initial begin
      cyc();
      chk = 1'b1;
      cyc();
      check("rst_instr", instr4, 16'h0000);
      check("rst_vld", 16'(vld4), 16'h0);
      check("rst_busy", 16'(busy4), 16'h0);
      rst_n = 1'b1;
      cyc(); cyc();
      check("idle_instr", instr4, 16'h0000);
      // basic fetch
      wr(16'd5, 16'h0312);
      req(16'd5);
      check("basic_busy1", 16'(busy4), 16'h1);
      cyc(); check("basic_busy2", 16'(busy4), 16'h1);
      cyc(); check("basic_busy3", 16'(busy4), 16'h1);
      check("basic_novld3", 16'(vld4), 16'h0);
      cyc(); check("basic_vld", 16'(vld4), 16'h1);
      check("basic_instr", instr4, 16'h0312);
      check("basic_busy4", 16'(busy4), 16'h0);
      cyc(); check("basic_hold", instr4, 16'h0312);
      check("basic_vld_off", 16'(vld4), 16'h0);
      // back-to-back with an ignored request while busy
      wr(16'd0, 16'hB101); wr(16'd1, 16'hA100); wr(16'd2, 16'hB210);
      req(16'd0);
      rd_en = 1'b1; addr = 16'd2;
      cyc(); rd_en = 1'b0;
      cyc(); cyc();
      check("b2b_vld0", 16'(vld4), 16'h1);
      check("b2b_instr0", instr4, 16'hB101);
      req(16'd1);
      cyc(); cyc(); cyc();
      check("b2b_vld1", 16'(vld4), 16'h1);
      check("b2b_instr1", instr4, 16'hA100);
      cyc(); check("b2b_none", 16'(vld4), 16'h0);
      cyc(); cyc(); cyc();
      check("b2b_no_b210", instr4, 16'hA100);
      // flush redirect
      req(16'd0);
      cyc();
      flush = 1'b1; rd_en = 1'b1; addr = 16'd2;
      cyc(); flush = 1'b0; rd_en = 1'b0;
      cyc(); check("flush_novld", 16'(vld4), 16'h0);
      cyc(); cyc();
      check("flush_vld", 16'(vld4), 16'h1);
      check("flush_instr", instr4, 16'hB210);
      // flush on the completion edge
      req(16'd0);
      cyc(); cyc();
      flush = 1'b1;
      cyc(); flush = 1'b0;
      check("flushc_novld", 16'(vld4), 16'h0);
      check("flushc_instr", instr4, 16'hB210);
      check("flushc_busy", 16'(busy4), 16'h0);
      // flush while idle plus a request is a normal fetch
      flush = 1'b1; rd_en = 1'b1; addr = 16'd1;
      cyc(); flush = 1'b0; rd_en = 1'b0;
      cyc(); cyc(); cyc();
      check("flushi_instr", instr4, 16'hA100);
      check("flushi_vld", 16'(vld4), 16'h1);
      // address wrap and write hazards
      wr(16'd3, 16'hC4FF);
      req(16'h0403);
      cyc(); cyc(); cyc();
      check("wrap_instr", instr4, 16'hC4FF);
      req(16'd3);
      wr(16'd3, 16'h1112);
      cyc(); cyc();
      check("haz_early", instr4, 16'h1112);
      wr(16'd3, 16'hC4FF);
      req(16'd3);
      cyc(); cyc();
      wr(16'd3, 16'h1112);
      check("haz_late", instr4, 16'hC4FF);
      check("haz_late_vld", 16'(vld4), 16'h1);
      // reset mid-fetch, with a write attempted during reset
      req(16'd5);
      cyc();
      rst_n = 1'b0; wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'hFFFF;
      cyc(); rst_n = 1'b1; wr_en = 1'b0;
      check("rstm_instr", instr4, 16'h0000);
      cyc(); check("rstm_novld", 16'(vld4), 16'h0);
      cyc(); cyc(); check("rstm_novld2", 16'(vld4), 16'h0);
      req(16'd5);
      cyc(); cyc(); cyc();
      check("rst_wr_blocked", instr4, 16'h0312);
      // LATENCY=1 streaming
      rd_en = 1'b1; addr = 16'd0;
      cyc(); check("l1_vld0", 16'(vld1), 16'h1);
      check("l1_instr0", instr1, 16'hB101);
      addr = 16'd1;
      cyc(); check("l1_instr1", instr1, 16'hA100);
      check("l1_busy", 16'(busy1), 16'h0);
      addr = 16'd2;
      cyc(); rd_en = 1'b0;
      check("l1_instr2", instr1, 16'hB210);
      check("l1_vld2", 16'(vld1), 16'h1);
      cyc(); check("l1_vld_off", 16'(vld1), 16'h0);
      cyc(); cyc(); cyc(); cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
